// File: rtl/timer_scheduler.sv
// Shares one peripheral Timer among NUM_REQ requesters. Each request is a one-shot delay.
// A round-robin grant latches the request's settings, programs the Timer, waits for its interrupt, stops it, then pulses done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no owner; round-robin grant is offered on req_ready
// WR_PSC   | write prescaler register (0xC)
// WR_CMP   | write compare register (0x8)
// WR_START | write CONTROL with START_CTRL (0x0)
// WAIT_IRQ | wait for Timer interrupt or abort; first cycle is blanked
// WR_STOP  | write CONTROL with STOP_CTRL (0x0)
// DONE     | one-cycle done pulse to owner, done_aborted qualifies it
module timer_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] START_CTRL = 32'h0000_000B,
  parameter logic [31:0] STOP_CTRL  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_prescaler,
  input  logic [32*NUM_REQ-1:0] req_compare,
  input  logic                  abort,
  output logic [NUM_REQ-1:0]    done,
  output logic                  done_aborted,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [31:0]           tmr_address,
  output logic                  tmr_wr_en,
  output logic [31:0]           tmr_wr_data,
  input  logic                  tmr_interrupt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PSC, S_WR_CMP, S_WR_START, S_WAIT_IRQ, S_WR_STOP, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_grant;
  logic [31:0]     r_psc;
  logic [31:0]     r_cmp;
  logic            r_aborted;
  logic            r_blank;

  logic            w_found;
  logic [ID_W-1:0] w_win;
  int              w_idx;
  logic [31:0]     w_sel_psc;
  logic [31:0]     w_sel_cmp;
  logic            w_take;
  logic            w_irq_ok;

  // Search starts at r_ptr, which always holds (last grant + 1) mod NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_idx);
      end
    end
  end

  assign w_sel_psc = req_prescaler[32*int'(w_win) +: 32];
  assign w_sel_cmp = req_compare[32*int'(w_win) +: 32];
  assign w_take    = (r_state == S_IDLE) && w_found;
  assign w_irq_ok  = tmr_interrupt && !r_blank;
  assign req_ready = (rst && w_take) ? (NUM_REQ'(1) << w_win) : '0;
  assign grant_id  = r_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_take) w_next = (w_sel_cmp == 32'd0) ? S_DONE : S_WR_PSC;
      S_WR_PSC:   w_next = S_WR_CMP;
      S_WR_CMP:   w_next = S_WR_START;
      S_WR_START: w_next = S_WAIT_IRQ;
      S_WAIT_IRQ: if (abort || w_irq_ok) w_next = S_WR_STOP;
      S_WR_STOP:  w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_wr_en    = 1'b0;
    tmr_address  = 32'd0;
    tmr_wr_data  = 32'd0;
    done         = '0;
    done_aborted = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_WR_PSC: begin
        tmr_wr_en   = 1'b1;
        tmr_address = 32'h0000_000C;
        tmr_wr_data = r_psc;
      end
      S_WR_CMP: begin
        tmr_wr_en   = 1'b1;
        tmr_address = 32'h0000_0008;
        tmr_wr_data = r_cmp;
      end
      S_WR_START: begin
        tmr_wr_en   = 1'b1;
        tmr_wr_data = START_CTRL;
      end
      S_WR_STOP: begin
        tmr_wr_en   = 1'b1;
        tmr_wr_data = STOP_CTRL;
      end
      S_DONE: begin
        done         = NUM_REQ'(1) << r_grant;
        done_aborted = r_aborted;
      end
      default: ;
    endcase
  end

  // r_blank marks the first WAIT_IRQ cycle, while the reinit is still clearing the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_psc     <= 32'd0;
      r_cmp     <= 32'd0;
      r_aborted <= 1'b0;
      r_blank   <= 1'b0;
    end else begin
      r_blank <= (r_state == S_WR_START);
      if (w_take) begin
        r_psc     <= w_sel_psc;
        r_cmp     <= w_sel_cmp;
        r_grant   <= w_win;
        r_ptr     <= (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + ID_W'(1);
        r_aborted <= (w_sel_cmp == 32'd0);
      end
      if (r_state == S_WAIT_IRQ) begin
        if (abort)         r_aborted <= 1'b1;
        else if (w_irq_ok) r_aborted <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: stimulus pushes the expected Timer writes and done pulses.
// A negedge monitor pops and compares each one as the DUT presents it.
module tb_timer_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_prescaler = '0;
  logic [32*N-1:0] req_compare = '0;
  logic           abort = 1'b0;
  logic [N-1:0]   done;
  logic           done_aborted;
  logic           busy;
  logic [1:0]     grant_id;
  logic [31:0]    tmr_address;
  logic           tmr_wr_en;
  logic [31:0]    tmr_wr_data;
  logic           tmr_interrupt = 1'b0;

  timer_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_prescaler(req_prescaler), .req_compare(req_compare), .abort(abort),
    .done(done), .done_aborted(done_aborted), .busy(busy), .grant_id(grant_id),
    .tmr_address(tmr_address), .tmr_wr_en(tmr_wr_en), .tmr_wr_data(tmr_wr_data),
    .tmr_interrupt(tmr_interrupt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_done;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [N-1:0] dn;
    logic         ab;
    int           cyc;
  } ev_t;

  ev_t q[$];
  ev_t m_x;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.dn = '0; e.ab = 1'b0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_dn(input logic [N-1:0] dn, input logic ab, input int c);
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.dn = dn; e.ab = ab; e.cyc = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && (tmr_wr_en === 1'b1 || done !== '0)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got wr=%b addr=%0h data=%0h done=%b ab=%b at cycle %0d, expected none",
                 tmr_wr_en, tmr_address, tmr_wr_data, done, done_aborted, cyc);
      end else begin
        m_x = q.pop_front();
        if ((m_x.is_done != (done !== '0)) ||
            (m_x.is_done  && (done !== m_x.dn || done_aborted !== m_x.ab)) ||
            (!m_x.is_done && (tmr_wr_en !== 1'b1 || tmr_address !== m_x.addr || tmr_wr_data !== m_x.data)) ||
            (m_x.cyc >= 0 && m_x.cyc != cyc)) begin
          n_err++;
          $display("FAIL %s: got wr=%b addr=%0h data=%0h done=%b ab=%b cyc=%0d expected addr=%0h data=%0h done=%b ab=%b cyc=%0d",
                   m_x.is_done ? "done_pulse" : "tmr_write", tmr_wr_en, tmr_address, tmr_wr_data,
                   done, done_aborted, cyc, m_x.addr, m_x.data, m_x.dn, m_x.ab, m_x.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a clock edge with the DUT in IDLE; id must win the grant at the coming edge.
  // irq_c: WAIT_IRQ cycle from which the interrupt is held (0 = never); abort_c: cycle with abort (0 = never).
  task automatic serve(input int id, input logic [N-1:0] vld, input logic [N-1:0] vld_after,
                       input logic [31:0] psc, input logic [31:0] cmp,
                       input int irq_c, input int abort_c);
    int  k0;
    bit  exited;
    bit  irq_now;
    bit  ab_now;
    req_prescaler[32*id +: 32] = psc;
    req_compare[32*id +: 32]   = cmp;
    req_valid = vld;
    #1;
    k0 = cyc;
    chk($sformatf("req_ready_id%0d", id), 32'(req_ready), 32'(1) << id);
    chk("busy_idle", 32'(busy), 32'd0);
    if (cmp == 32'd0) begin
      push_dn(N'(1) << id, 1'b1, -1);
      tick();
      req_valid = vld_after;
      chk("grant_id_zero", 32'(grant_id), 32'(id));
      tick();
      chk("busy_after_zero", 32'(busy), 32'd0);
      return;
    end
    push_wr(32'hC, psc, k0 + 1);
    push_wr(32'h8, cmp, k0 + 2);
    push_wr(32'h0, 32'hB, k0 + 3);
    tick();
    req_valid = vld_after;
    chk("grant_id", 32'(grant_id), 32'(id));
    tick();
    tick();
    exited = 1'b0;
    for (int w = 1; w <= 20 && !exited; w++) begin
      tick();
      irq_now = (irq_c > 0) && (w >= irq_c);
      ab_now  = (w == abort_c);
      tmr_interrupt = irq_now;
      abort         = ab_now;
      if (ab_now || (irq_now && w >= 2)) begin
        exited = 1'b1;
        push_wr(32'h0, 32'h0, k0 + 4 + w);
        push_dn(N'(1) << id, ab_now, k0 + 5 + w);
      end
    end
    if (!exited) chk("wait_exit", 32'd0, 32'd1);
    tick();
    tmr_interrupt = 1'b0;
    abort = 1'b0;
    chk("busy_wr_stop", 32'(busy), 32'd1);
    tick();
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int k0;
    req_valid = 4'b1111;
    req_compare = {N{32'd7}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_aborted", 32'(done_aborted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmr_wr_en", 32'(tmr_wr_en), 32'd0);
    chk("rst_tmr_address", tmr_address, 32'd0);
    chk("rst_tmr_wr_data", tmr_wr_data, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    req_valid = '0;
    req_compare = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    serve(0, 4'b0001, 4'b0000, 32'd3, 32'd5, 2, 0);
    serve(1, 4'b0010, 4'b0000, 32'd7, 32'd9, 1, 0);
    serve(2, 4'b0100, 4'b0000, 32'd1, 32'd2, 0, 3);
    serve(3, 4'b1000, 4'b0000, 32'd4, 32'd6, 3, 3);
    serve(2, 4'b0100, 4'b0000, 32'd5, 32'd0, 0, 0);

    // Reset during WR_CMP of a grant to requester 2 (pointer now favours 3).
    req_prescaler[64 +: 32] = 32'd8;
    req_compare[64 +: 32]   = 32'd9;
    req_valid = 4'b0100;
    #1;
    k0 = cyc;
    chk("req_ready_pre_rst", 32'(req_ready), 32'b0100);
    push_wr(32'hC, 32'd8, k0 + 1);
    tick();
    req_valid = '0;
    tick();
    chk("tmr_wr_en_in_wr_cmp", 32'(tmr_wr_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(tmr_wr_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_address", tmr_address, 32'd0);
    chk("queue_drained_rst", 32'(q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    serve(0, 4'b1011, 4'b1011, 32'd2, 32'd3, 2, 0);
    serve(1, 4'b1011, 4'b1011, 32'd6, 32'd1, 4, 0);
    serve(3, 4'b1011, 4'b1011, 32'd9, 32'd8, 0, 1);
    serve(0, 4'b1011, 4'b0000, 32'd2, 32'd4, 2, 0);

    repeat (4) tick();
    chk("queue_empty_end", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
